midi_in_parser: RTL and testbench

- Single-clock MIDI receiver and message parser, parametrised successor to the fixed-length MIDI input block.
- UART framing is oversampled on the system clock; no derived baud clock.
- Parses variable-length channel and system-common messages with running status.
- Real-time bytes bypass the parser on their own strobe; channel messages pass through a per-channel filter. Sits between the board MIDI_IN pin and the synth/voice-allocation logic.

---
 rtl/midi_in_parser.sv | 186 ++++++++++++++++++
 tb/tb_midi_in_parser.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_in_parser.sv
// MIDI input receiver and message parser: oversampled UART framing on clk,
// running-status message assembly, real-time bypass and per-channel filtering.
module midi_in_parser #(
  parameter int CLKS_PER_BIT = 3200,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        midi_rx,
  input  logic [15:0] channel_mask,
  output logic        msg_valid,
  output logic [7:0]  status_out,
  output logic [7:0]  data1_out,
  output logic [7:0]  data2_out,
  output logic [1:0]  bytes_cnt,
  output logic        rt_valid,
  output logic [7:0]  rt_byte,
  output logic        sysex_active,
  output logic        framing_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_START      = 3'd1;
  localparam logic [2:0] S_DATA       = 3'd2;
  localparam logic [2:0] S_STOP       = 3'd3;
  localparam logic [2:0] S_BREAK_WAIT = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx;
  logic [2:0]             rx_state;
  logic [CW-1:0]          clk_cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift_q;
  logic                   byte_stb;

  // NOTE: synchroniser resets to the idle-high line level so a reset release
  // never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], midi_rx};
  end

  assign rx = sync_q[SYNC_STAGES-1];

  // NOTE: strobes get a non-blocking default of 0 at the top of the clocked
  // block, so each branch only has to raise them for a single cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state    <= S_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_q     <= '0;
      byte_stb    <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      byte_stb    <= 1'b0;
      framing_err <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (!rx) begin
            clk_cnt  <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt  <= '0;
            bit_idx  <= '0;
            rx_state <= rx ? S_IDLE : S_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            shift_q <= {rx, shift_q[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (rx) begin
              byte_stb <= 1'b1;
              rx_state <= S_IDLE;
            end else begin
              framing_err <= 1'b1;
              rx_state    <= S_BREAK_WAIT;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_BREAK_WAIT: begin
          if (rx) rx_state <= S_IDLE;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // Parser: run_status == 0 means no running status (valid statuses have MSB set).
  logic [7:0] run_status;
  logic [1:0] exp_cnt;
  logic       have_d1;
  logic [7:0] d1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_status   <= '0;
      exp_cnt      <= '0;
      have_d1      <= 1'b0;
      d1_q         <= '0;
      msg_valid    <= 1'b0;
      status_out   <= '0;
      data1_out    <= '0;
      data2_out    <= '0;
      bytes_cnt    <= '0;
      rt_valid     <= 1'b0;
      rt_byte      <= '0;
      sysex_active <= 1'b0;
    end else begin
      msg_valid <= 1'b0;
      rt_valid  <= 1'b0;
      if (byte_stb) begin
        if (&shift_q[7:3]) begin
          rt_valid <= 1'b1;
          rt_byte  <= shift_q;
        end else if (shift_q[7]) begin
          have_d1      <= 1'b0;
          sysex_active <= (shift_q == 8'hF0);
          run_status   <= '0;
          exp_cnt      <= 2'd3;
          if (shift_q[7:4] != 4'hF) begin
            run_status <= shift_q;
            exp_cnt    <= (shift_q[7:5] == 3'b110) ? 2'd2 : 2'd3;
          end else begin
            case (shift_q[3:0])
              4'h1, 4'h3: begin
                run_status <= shift_q;
                exp_cnt    <= 2'd2;
              end
              4'h2: begin
                run_status <= shift_q;
                exp_cnt    <= 2'd3;
              end
              4'h6: begin
                msg_valid  <= 1'b1;
                status_out <= shift_q;
                data1_out  <= '0;
                data2_out  <= '0;
                bytes_cnt  <= 2'd1;
              end
              default: ;
            endcase
          end
        end else if (!sysex_active && run_status[7]) begin
          if (!have_d1 && exp_cnt == 2'd3) begin
            d1_q    <= shift_q;
            have_d1 <= 1'b1;
          end else begin
            // Message complete: system-common messages do not keep running status.
            have_d1 <= 1'b0;
            if (run_status[7:4] == 4'hF) run_status <= '0;
            if (run_status[7:4] == 4'hF || channel_mask[run_status[3:0]]) begin
              msg_valid  <= 1'b1;
              status_out <= run_status;
              data1_out  <= have_d1 ? d1_q : shift_q;
              data2_out  <= have_d1 ? shift_q : 8'h00;
              bytes_cnt  <= exp_cnt;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_in_parser.sv
// Self-checking bench for midi_in_parser: directed scenarios plus random byte
// streams compared against a message-level model of the MIDI protocol.
module tb_midi_in_parser;
  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        midi_rx = 1'b1;
  logic [15:0] channel_mask = 16'hFFFF;
  logic        msg_valid, rt_valid, sysex_active, framing_err;
  logic [7:0]  status_out, data1_out, data2_out, rt_byte;
  logic [1:0]  bytes_cnt;

  midi_in_parser #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .midi_rx(midi_rx), .channel_mask(channel_mask),
    .msg_valid(msg_valid), .status_out(status_out), .data1_out(data1_out),
    .data2_out(data2_out), .bytes_cnt(bytes_cnt), .rt_valid(rt_valid),
    .rt_byte(rt_byte), .sysex_active(sysex_active), .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] n;
  } msg_t;

  msg_t       exp_q[$];
  logic [7:0] rt_q[$];
  int checks = 0, failures = 0;
  int mv_count = 0, rt_count = 0, fe_count = 0;

  // Protocol model state
  int         m_rs = -1;
  logic [7:0] m_data[$];
  bit         m_sysex = 1'b0;
  msg_t       m_last = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int msg_len(input int s);
    if (s >= 'hF0) return (s == 'hF2) ? 3 : 2;
    if ((s >> 4) == 'hC || (s >> 4) == 'hD) return 2;
    return 3;
  endfunction

  task automatic model_emit(input msg_t m);
    if (m.st < 8'hF0 && !channel_mask[m.st[3:0]]) return;
    exp_q.push_back(m);
    m_last = m;
  endtask

  task automatic model_byte(input logic [7:0] b);
    msg_t m;
    if (b >= 8'hF8) begin
      rt_q.push_back(b);
      return;
    end
    if (b[7]) begin
      m_data.delete();
      m_sysex = (b == 8'hF0);
      if (b < 8'hF0 || b == 8'hF1 || b == 8'hF2 || b == 8'hF3) m_rs = int'(b);
      else m_rs = -1;
      if (b == 8'hF6) begin
        m = '{st: 8'hF6, d1: 8'h00, d2: 8'h00, n: 2'd1};
        model_emit(m);
      end
      return;
    end
    if (m_sysex || m_rs < 0) return;
    m_data.push_back(b);
    if (m_data.size() + 1 == msg_len(m_rs)) begin
      m.st = 8'(m_rs);
      m.d1 = m_data[0];
      m.d2 = (m_data.size() > 1) ? m_data[1] : 8'h00;
      m.n  = 2'(msg_len(m_rs));
      model_emit(m);
      m_data.delete();
      if (m_rs >= 'hF0) m_rs = -1;
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_ok);
    @(negedge clk) midi_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    midi_rx = stop_ok;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic end_check();
    check("pending_msg", exp_q.size(), 0);
    check("pending_rt", rt_q.size(), 0);
    exp_q.delete();
    rt_q.delete();
    check("hold_status", status_out, m_last.st);
    check("hold_data1", data1_out, m_last.d1);
    check("hold_data2", data2_out, m_last.d2);
    check("hold_bytes_cnt", bytes_cnt, m_last.n);
    check("sysex_active", sysex_active, m_sysex);
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    drive_frame(b, 1'b1);
    midi_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    end_check();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_msg_valid"}, msg_valid, 0);
    check({tag, "_status"}, status_out, 0);
    check({tag, "_data1"}, data1_out, 0);
    check({tag, "_data2"}, data2_out, 0);
    check({tag, "_bytes_cnt"}, bytes_cnt, 0);
    check({tag, "_rt_valid"}, rt_valid, 0);
    check({tag, "_rt_byte"}, rt_byte, 0);
    check({tag, "_sysex"}, sysex_active, 0);
    check({tag, "_framing_err"}, framing_err, 0);
  endtask

  initial begin
    int mv0, rt0, fe0, r;
    logic [7:0] b;

    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          if (msg_valid && rt_valid) check("mv_rt_exclusive", {msg_valid, rt_valid}, 2'b10);
          if (msg_valid) begin
            mv_count++;
            if (exp_q.size() == 0) check("unexpected_msg", exp_q.size(), 1);
            else begin
              msg_t m;
              m = exp_q.pop_front();
              check("msg_status", status_out, m.st);
              check("msg_data1", data1_out, m.d1);
              check("msg_data2", data2_out, m.d2);
              check("msg_bytes_cnt", bytes_cnt, m.n);
            end
          end
          if (rt_valid) begin
            rt_count++;
            if (rt_q.size() == 0) check("unexpected_rt", rt_q.size(), 1);
            else check("rt_byte", rt_byte, rt_q.pop_front());
          end
          if (framing_err) fe_count++;
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_all_zero("after_reset");

    // Note on with explicit status
    mv0 = mv_count;
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    check("t1_count", mv_count - mv0, 1);
    check("t1_status", status_out, 8'h90);
    check("t1_data1", data1_out, 8'h3C);
    check("t1_data2", data2_out, 8'h64);
    check("t1_bytes", bytes_cnt, 2'd3);

    // Running status
    mv0 = mv_count;
    send_byte(8'h40); send_byte(8'h00);
    check("t2_count", mv_count - mv0, 1);
    check("t2_status", status_out, 8'h90);
    check("t2_data1", data1_out, 8'h40);
    check("t2_data2", data2_out, 8'h00);

    // Program change, then real-time byte inside a note message
    send_byte(8'hC3); send_byte(8'h05);
    check("t3_pc_status", status_out, 8'hC3);
    check("t3_pc_data1", data1_out, 8'h05);
    check("t3_pc_data2", data2_out, 8'h00);
    check("t3_pc_bytes", bytes_cnt, 2'd2);
    rt0 = rt_count;
    send_byte(8'h90); send_byte(8'hF8); send_byte(8'h3C); send_byte(8'h64);
    check("t3_rt_count", rt_count - rt0, 1);
    check("t3_rt_byte", rt_byte, 8'hF8);
    check("t3_note_data1", data1_out, 8'h3C);
    check("t3_note_data2", data2_out, 8'h64);

    // Channel filter
    channel_mask = 16'h0001;
    mv0 = mv_count;
    send_byte(8'h91); send_byte(8'h40); send_byte(8'h7F);
    check("t4_filtered", mv_count - mv0, 0);
    send_byte(8'h90); send_byte(8'h40); send_byte(8'h7F);
    check("t4_passed", mv_count - mv0, 1);
    channel_mask = 16'hFFFF;

    // SysEx and tune request
    mv0 = mv_count;
    send_byte(8'hF0);
    check("t5_sysex_on", sysex_active, 1'b1);
    send_byte(8'h7E); send_byte(8'h01);
    send_byte(8'hF7);
    check("t5_sysex_off", sysex_active, 1'b0);
    send_byte(8'h3C);
    send_byte(8'hF6);
    check("t5_count", mv_count - mv0, 1);
    check("t5_status", status_out, 8'hF6);
    check("t5_bytes", bytes_cnt, 2'd1);

    // Framing error with a break
    fe0 = fe_count; mv0 = mv_count; rt0 = rt_count;
    drive_frame(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    midi_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("t6_framing_err", fe_count - fe0, 1);
    end_check();

    // Short glitch on the line
    midi_rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    midi_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("t6_glitch_msgs", (mv_count - mv0) + (rt_count - rt0), 0);
    check("t6_glitch_fe", fe_count - fe0, 1);
    end_check();

    // Reset in the middle of a frame's data bits
    midi_rx = 1'b0;
    repeat (CPB + CPB / 2 + 2 * CPB) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    midi_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    m_rs = -1; m_data.delete(); m_sysex = 1'b0; m_last = '0;
    repeat (2 * CPB) @(negedge clk);
    check_all_zero("post_reset");
    mv0 = mv_count;
    send_byte(8'h80); send_byte(8'h40); send_byte(8'h00);
    check("t6_count", mv_count - mv0, 1);
    check("t6_status", status_out, 8'h80);
    check("t6_data1", data1_out, 8'h40);
    check("t6_bytes", bytes_cnt, 2'd3);

    // Random byte stream
    for (int k = 0; k < 180; k++) begin
      if ($urandom_range(0, 15) == 0) channel_mask = 16'($urandom);
      r = $urandom_range(0, 99);
      if (r < 45)      b = 8'($urandom_range(0, 127));
      else if (r < 75) b = 8'($urandom_range(128, 239));
      else if (r < 85) b = 8'($urandom_range(248, 255));
      else             b = 8'($urandom_range(240, 247));
      send_byte(b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
